// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings, widths and default parameter values for the pipeline
// stall/flush controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MULDIV     = 2'd2
  } ctrl_state_e;

  localparam int STALL_CNT_W       = 16;
  localparam int WAIT_CNT_W        = 8;
  localparam int MULDIV_CNT_W      = 4;
  localparam int MULDIV_CYCLES_DEF = 4;
  localparam int MAX_MEM_WAIT_DEF  = 15;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard requests into the controller and pipeline enables/flushes out of it.
interface pipeline_stall_controller_if;
  logic       load_use_hazard;
  logic       branch_taken;
  logic       mem_busy;
  logic       muldiv_start;
  logic       PC_write;
  logic       IF_ID_write;
  logic       IF_ID_flush;
  logic       ID_EXE_write;
  logic       ID_EXE_flush;
  logic       EXE_MEM_write;
  logic       EXE_MEM_flush;
  logic       mem_timeout;
  logic [1:0] ctrl_state;
  logic [15:0] stall_count;

  // Pipeline side: raises hazard requests, consumes the controls.
  modport master (
    output load_use_hazard, branch_taken, mem_busy, muldiv_start,
    input  PC_write, IF_ID_write, IF_ID_flush, ID_EXE_write, ID_EXE_flush,
           EXE_MEM_write, EXE_MEM_flush, mem_timeout, ctrl_state, stall_count
  );

  // Controller side.
  modport slave (
    input  load_use_hazard, branch_taken, mem_busy, muldiv_start,
    output PC_write, IF_ID_write, IF_ID_flush, ID_EXE_write, ID_EXE_flush,
           EXE_MEM_write, EXE_MEM_flush, mem_timeout, ctrl_state, stall_count
  );
endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  // Next count: clear, else increment unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Fixed-priority stall/freeze/flush sequencer for the 5-stage pipeline:
// mem_busy > mul/div > branch > load-use. Controls are combinational from
// state and inputs; state and debug counters are registered.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF,
  parameter int MAX_MEM_WAIT  = MAX_MEM_WAIT_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  pipeline_stall_controller_if.slave  bus
);

  ctrl_state_e             state_q, state_d;
  logic [MULDIV_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic                    timeout_q, timeout_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic [STALL_CNT_W-1:0]  stall_cnt;

  // Arbitration: outputs and next state, defaults first.
  always_comb begin
    bus.PC_write      = 1'b1;
    bus.IF_ID_write   = 1'b1;
    bus.IF_ID_flush   = 1'b0;
    bus.ID_EXE_write  = 1'b1;
    bus.ID_EXE_flush  = 1'b0;
    bus.EXE_MEM_write = 1'b1;
    bus.EXE_MEM_flush = 1'b0;
    state_d           = state_q;
    md_cnt_d          = md_cnt_q;
    if (reset) begin
      state_d  = RUN;
      md_cnt_d = '0;
    end else if (bus.mem_busy) begin
      // Whole pipe freezes; state and mul/div count hold.
      bus.PC_write      = 1'b0;
      bus.IF_ID_write   = 1'b0;
      bus.ID_EXE_write  = 1'b0;
      bus.EXE_MEM_write = 1'b0;
    end else if (state_q == MULDIV) begin
      bus.PC_write      = 1'b0;
      bus.IF_ID_write   = 1'b0;
      bus.ID_EXE_write  = 1'b0;
      bus.EXE_MEM_flush = 1'b1;
      // Leave when the count reaches zero so the stall is MULDIV_CYCLES-1 long.
      md_cnt_d = md_cnt_q - MULDIV_CNT_W'(1);
      if (md_cnt_q <= MULDIV_CNT_W'(1)) state_d = RUN;
    end else if (bus.muldiv_start) begin
      bus.PC_write      = 1'b0;
      bus.IF_ID_write   = 1'b0;
      bus.ID_EXE_write  = 1'b0;
      bus.EXE_MEM_flush = 1'b1;
      md_cnt_d          = MULDIV_CNT_W'(MULDIV_CYCLES - 2);
      state_d           = (MULDIV_CYCLES == 2) ? RUN : MULDIV;
    end else if (bus.branch_taken) begin
      // Kills the two younger instructions, including any load-use victim.
      bus.IF_ID_flush  = 1'b1;
      bus.ID_EXE_flush = 1'b1;
      state_d          = RUN;
    end else if (bus.load_use_hazard && (state_q == RUN)) begin
      bus.PC_write     = 1'b0;
      bus.IF_ID_write  = 1'b0;
      bus.ID_EXE_flush = 1'b1;
      state_d          = LOAD_STALL;
    end else begin
      state_d = RUN;
    end
  end

  // Sticky timeout: set on the busy cycle that brings the wait count to the limit.
  always_comb begin
    timeout_d = timeout_q;
    if (bus.mem_busy && (wait_cnt >= WAIT_CNT_W'(MAX_MEM_WAIT - 1))) timeout_d = 1'b1;
  end

  // State, mul/div counter and timeout flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      md_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      md_cnt_q  <= md_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(.W(WAIT_CNT_W)) u_wait_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc     (bus.mem_busy),
    .clr     (!bus.mem_busy),
    .count_o (wait_cnt)
  );

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc     (!bus.PC_write),
    .clr     (1'b0),
    .count_o (stall_cnt)
  );

  assign bus.mem_timeout = timeout_q;
  assign bus.ctrl_state  = state_q;
  assign bus.stall_count = stall_cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with a cycle-level model of
// the hazard rules and literal spot checks.
module tb_pipeline_stall_controller;

  localparam int MC  = 4;
  localparam int MAX = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_stall_controller_if bus ();

  pipeline_stall_controller #(.MULDIV_CYCLES(MC), .MAX_MEM_WAIT(MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state: remaining mul/div stall cycles after the start cycle,
  // whether the one-cycle load shadow is active, and the debug counters.
  int m_rem  = 0;
  bit m_ls   = 1'b0;
  int m_wait = 0;
  bit m_to   = 1'b0;
  int m_sc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, then advance the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit e_pc, e_ifw, e_iff, e_idw, e_idf, e_emw, e_emf;
      int e_st;
      e_pc = 1; e_ifw = 1; e_iff = 0; e_idw = 1; e_idf = 0; e_emw = 1; e_emf = 0;
      if (reset) begin
      end else if (bus.mem_busy) begin
        e_pc = 0; e_ifw = 0; e_idw = 0; e_emw = 0;
      end else if (m_rem > 0 || bus.muldiv_start) begin
        e_pc = 0; e_ifw = 0; e_idw = 0; e_emf = 1;
      end else if (bus.branch_taken) begin
        e_iff = 1; e_idf = 1;
      end else if (bus.load_use_hazard && !m_ls) begin
        e_pc = 0; e_ifw = 0; e_idf = 1;
      end
      e_st = (m_rem > 0) ? 2 : (m_ls ? 1 : 0);
      chk("PC_write", 32'(bus.PC_write), 32'(e_pc));
      chk("IF_ID_write", 32'(bus.IF_ID_write), 32'(e_ifw));
      chk("IF_ID_flush", 32'(bus.IF_ID_flush), 32'(e_iff));
      chk("ID_EXE_write", 32'(bus.ID_EXE_write), 32'(e_idw));
      chk("ID_EXE_flush", 32'(bus.ID_EXE_flush), 32'(e_idf));
      chk("EXE_MEM_write", 32'(bus.EXE_MEM_write), 32'(e_emw));
      chk("EXE_MEM_flush", 32'(bus.EXE_MEM_flush), 32'(e_emf));
      chk("ctrl_state", 32'(bus.ctrl_state), 32'(e_st));
      chk("stall_count", 32'(bus.stall_count), 32'(m_sc));
      chk("mem_timeout", 32'(bus.mem_timeout), 32'(m_to));
      if (reset) begin
        m_rem = 0; m_ls = 0; m_wait = 0; m_to = 0; m_sc = 0;
      end else begin
        if (!e_pc && m_sc < 65535) m_sc++;
        if (bus.mem_busy) begin
          if (m_wait + 1 >= MAX) m_to = 1;
          m_wait = (m_wait < 255) ? m_wait + 1 : 255;
        end else begin
          m_wait = 0;
          if (m_rem > 0) begin
            m_rem--; m_ls = 0;
          end else if (bus.muldiv_start) begin
            m_rem = MC - 2; m_ls = 0;
          end else begin
            m_ls = !bus.branch_taken && bus.load_use_hazard && !m_ls;
          end
        end
      end
    end
  end

  task automatic set_in(input bit rst, input bit lu, input bit br, input bit mb, input bit ms);
    reset = rst;
    bus.load_use_hazard = lu;
    bus.branch_taken    = br;
    bus.mem_busy        = mb;
    bus.muldiv_start    = ms;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(1, 0, 0, 0, 0);
    tick();
    chk_en = 1'b1;
    tick();
    set_in(0, 0, 0, 0, 0);
    chk("rst_state", 32'(bus.ctrl_state), 0);
    chk("rst_stall_count", 32'(bus.stall_count), 0);
    chk("rst_timeout", 32'(bus.mem_timeout), 0);
    tick();

    // Load-use: one bubble, one LOAD_STALL cycle.
    set_in(0, 1, 0, 0, 0); #1;
    chk("lu_pc", 32'(bus.PC_write), 0);
    chk("lu_ifid_w", 32'(bus.IF_ID_write), 0);
    chk("lu_idexe_f", 32'(bus.ID_EXE_flush), 1);
    tick();
    set_in(0, 0, 0, 0, 0); #1;
    chk("lu_state_ls", 32'(bus.ctrl_state), 1);
    chk("lu_pc_next", 32'(bus.PC_write), 1);
    tick();
    chk("lu_state_run", 32'(bus.ctrl_state), 0);
    chk("lu_stall_count", 32'(bus.stall_count), 1);
    chk("model_sc_lu", 32'(m_sc), 1);

    // Mul/div: three stall cycles.
    set_in(0, 0, 0, 0, 1); #1;
    chk("md_pc", 32'(bus.PC_write), 0);
    chk("md_emf", 32'(bus.EXE_MEM_flush), 1);
    tick();
    set_in(0, 0, 0, 0, 0);
    chk("md_state", 32'(bus.ctrl_state), 2);
    repeat (5) tick();
    chk("md_stall_count", 32'(bus.stall_count), 4);
    chk("md_state_run", 32'(bus.ctrl_state), 0);

    // Branch with simultaneous load-use: flush wins, no stall.
    set_in(0, 1, 1, 0, 0); #1;
    chk("br_iff", 32'(bus.IF_ID_flush), 1);
    chk("br_idf", 32'(bus.ID_EXE_flush), 1);
    chk("br_pc", 32'(bus.PC_write), 1);
    tick();
    set_in(0, 0, 0, 0, 0);
    chk("br_state", 32'(bus.ctrl_state), 0);
    chk("br_stall_count", 32'(bus.stall_count), 4);

    // Back-to-back load-use: the second request falls in LOAD_STALL.
    set_in(0, 1, 0, 0, 0);
    tick(); #1;
    chk("ls_ignore_pc", 32'(bus.PC_write), 1);
    tick();
    set_in(0, 0, 0, 0, 0);
    tick();
    chk("ls_stall_count", 32'(bus.stall_count), 5);

    // Memory wait inside mul/div: stall stretches from 3 to 5.
    set_in(0, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 1, 0);
    tick();
    tick();
    set_in(0, 0, 0, 0, 0); #1;
    chk("mdmb_state", 32'(bus.ctrl_state), 2);
    repeat (4) tick();
    chk("mdmb_stall_count", 32'(bus.stall_count), 10);
    chk("model_sc_mdmb", 32'(m_sc), 10);

    // Timeout after the 15th consecutive busy cycle, sticky afterwards.
    set_in(0, 0, 0, 1, 0);
    repeat (14) tick();
    chk("to_before", 32'(bus.mem_timeout), 0);
    tick();
    chk("to_set", 32'(bus.mem_timeout), 1);
    set_in(0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("to_sticky", 32'(bus.mem_timeout), 1);
    chk("to_stall_count", 32'(bus.stall_count), 25);

    // Reset during the second MULDIV cycle.
    set_in(0, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 0, 0); #1;
    chk("rmd_pc_default", 32'(bus.PC_write), 1);
    chk("rmd_emf_default", 32'(bus.EXE_MEM_flush), 0);
    tick();
    set_in(0, 0, 0, 0, 0);
    chk("rmd_state", 32'(bus.ctrl_state), 0);
    chk("rmd_stall_count", 32'(bus.stall_count), 0);
    chk("rmd_timeout", 32'(bus.mem_timeout), 0);
    chk("rmd_pc", 32'(bus.PC_write), 1);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
